// File: rtl/matrix_mac_seq.sv
// Sequential outer-product MAC engine: acc[r][c] (+)= A[c]*B[r], one row per cycle, rows read out over valid/ready.
// Optional build macro MATRIX_MAC_SAT_EN selects unsigned saturating reduction instead of modulo wrap.
module matrix_mac_seq #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [LANES*ELEM_W-1:0]    op_A,
  input  logic [LANES*ELEM_W-1:0]    op_B,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [LANES*ACC_W-1:0]     res_data,
  output logic [$clog2(LANES)-1:0]   res_row,
  output logic                       mac_done,
  output logic                       busy
);

  localparam int ROW_W  = $clog2(LANES);
  localparam int PROD_W = 2 * ELEM_W;
  localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_MAC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {IDLE, COMPUTE, READOUT} state_t;

  state_t            state, state_next;
  logic [ROW_W-1:0]  row, row_next;
  logic              done, done_next;
  logic              load_mode;
  logic              accept, do_clear, do_start, do_write, last_row;

  logic [ACC_W-1:0]  acc     [LANES][LANES];
  logic [ELEM_W-1:0] a_lat   [LANES];
  logic [ELEM_W-1:0] b_lat   [LANES];
  logic [ACC_W-1:0]  row_new [LANES];
  logic [ELEM_W-1:0] b_cur;

  assign accept    = cmd_valid && cmd_ready;
  assign last_row  = (row == ROW_W'(LANES - 1));
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = (state == READOUT);
  assign res_row   = row;
  assign mac_done  = done;
  assign b_cur     = b_lat[row];

  always_comb begin
    state_next = state;
    row_next   = row;
    done_next  = 1'b0;
    do_clear   = 1'b0;
    do_start   = 1'b0;
    do_write   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLEAR: do_clear = 1'b1;
            OP_MAC, OP_LOAD: begin
              do_start   = 1'b1;
              state_next = COMPUTE;
              row_next   = '0;
            end
            OP_READ: begin
              state_next = READOUT;
              row_next   = '0;
            end
            default: ;
          endcase
        end
      end
      COMPUTE: begin
        do_write = 1'b1;
        if (last_row) begin
          state_next = IDLE;
          row_next   = '0;
          done_next  = 1'b1;
        end else begin
          row_next = row + 1'b1;
        end
      end
      READOUT: begin
        if (res_ready) begin
          if (last_row) begin
            state_next = IDLE;
            row_next   = '0;
          end else begin
            row_next = row + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        row_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      row   <= row_next;
      done  <= done_next;
    end
  end

  // Operands are captured once at accept so the pipeline may move on immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_mode <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        a_lat[i] <= '0;
        b_lat[i] <= '0;
      end
    end else if (do_start) begin
      load_mode <= (cmd_op == OP_LOAD);
      for (int i = 0; i < LANES; i++) begin
        a_lat[i] <= op_A[i*ELEM_W +: ELEM_W];
        b_lat[i] <= op_B[i*ELEM_W +: ELEM_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < LANES; r++)
        for (int c = 0; c < LANES; c++)
          acc[r][c] <= '0;
    end else if (do_clear) begin
      for (int r = 0; r < LANES; r++)
        for (int c = 0; c < LANES; c++)
          acc[r][c] <= '0;
    end else if (do_write) begin
      for (int c = 0; c < LANES; c++)
        acc[row][c] <= row_new[c];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : lane_g
      logic [PROD_W-1:0] prod;
      logic [ACC_W-1:0]  acc_term;

      assign prod     = {{ELEM_W{1'b0}}, a_lat[gi]} * {{ELEM_W{1'b0}}, b_cur};
      assign acc_term = load_mode ? '0 : acc[row][gi];

`ifdef MATRIX_MAC_SAT_EN
      logic [SUM_W-1:0] sum;
      assign sum         = SUM_W'(acc_term) + SUM_W'(prod);
      assign row_new[gi] = (|sum[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      assign row_new[gi] = ACC_W'(SUM_W'(acc_term) + SUM_W'(prod));
`endif

      assign res_data[gi*ACC_W +: ACC_W] = acc[row][gi];
    end
  endgenerate

endmodule

// File: tb/tb_matrix_mac_seq.sv
// Self-checking bench for matrix_mac_seq: table of command/readout vectors plus stall and reset-abort sequences.
module tb_matrix_mac_seq;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_MAC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] op_A;
  logic [31:0] op_B;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_row;
  logic        mac_done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  matrix_mac_seq #(.LANES(4), .ELEM_W(8), .ACC_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .op_A(op_A), .op_B(op_B),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row),
    .mac_done(mac_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        op;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [3:0][31:0]  e;
  } vec_t;

  vec_t vec [6];

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.e[0] = r0; v.e[1] = r1; v.e[2] = r2; v.e[3] = r3;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // mac_done and res_valid must never coincide
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (mac_done && res_valid) begin
        n_err++;
        $display("FAIL done_valid_overlap: got mac_done=1 res_valid=1 expected not both at %0t", $time);
      end
    end
  end

  // Returns at the negedge after the accept edge, with cmd_valid dropped and operands scrambled.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    op_A      = a;
    op_B      = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    op_A      = ~a;
    op_B      = ~b;
    $display("cmd op=%0d A=0x%08h B=0x%08h", op, a, b);
  endtask

  task automatic check_compute();
    int low  = 0;
    int done = 0;
    check("busy_in_compute", {63'd0, busy}, 64'd1);
    for (int k = 0; k < 8; k++) begin
      if (!cmd_ready) low++;
      if (mac_done) done++;
      @(negedge clk);
    end
    check("cmd_ready_low_cycles", 64'(low), 64'd4);
    check("mac_done_pulses", 64'(done), 64'd1);
  endtask

  task automatic read_check(input logic [3:0][31:0] e, input int stall_row, input int stall_n);
    send_cmd(OP_READ, 32'h0, 32'h0);
    for (int r = 0; r < 4; r++) begin
      int waited = 0;
      while (!res_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("res_valid", {63'd0, res_valid}, 64'd1);
      check("res_row", {62'd0, res_row}, 64'(r));
      check("res_data", {32'd0, res_data}, {32'd0, e[r]});
      $display("row %0d data=0x%08h expected=0x%08h", res_row, res_data, e[r]);
      if (r == stall_row) begin
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check("stall_row", {62'd0, res_row}, 64'(r));
          check("stall_data", {32'd0, res_data}, {32'd0, e[r]});
          check("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        end
        res_ready = 1'b1;
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("res_valid_after", {63'd0, res_valid}, 64'd0);
    check("cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    logic [3:0][31:0] zeros;
    logic [3:0][31:0] base;
    int rst_done;
    zeros = '0;
    base[0] = 32'h100C0804; base[1] = 32'h0C090603;
    base[2] = 32'h08060402; base[3] = 32'h04030201;

    vec[0] = mk(OP_CLEAR, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vec[1] = mk(OP_LOAD, 32'h04030201, 32'h01020304, 32'h100C0804, 32'h0C090603, 32'h08060402, 32'h04030201);
    vec[2] = mk(OP_MAC,  32'h04030201, 32'h01020304, 32'h20181008, 32'h18120C06, 32'h100C0804, 32'h08060402);
`ifdef MATRIX_MAC_SAT_EN
    vec[3] = mk(OP_LOAD, 32'h000000FF, 32'h000000FF, 32'h000000FF, 32'h0, 32'h0, 32'h0);
`else
    vec[3] = mk(OP_LOAD, 32'h000000FF, 32'h000000FF, 32'h00000001, 32'h0, 32'h0, 32'h0);
`endif
    vec[4] = mk(OP_LOAD, 32'h10203040, 32'h01010101, 32'h10203040, 32'h10203040, 32'h10203040, 32'h10203040);
`ifdef MATRIX_MAC_SAT_EN
    vec[5] = mk(OP_MAC,  32'h80808080, 32'h02020202, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    vec[5] = mk(OP_MAC,  32'h80808080, 32'h02020202, 32'h10203040, 32'h10203040, 32'h10203040, 32'h10203040);
`endif

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_CLEAR; op_A = '0; op_B = '0; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_mac_done", {63'd0, mac_done}, 64'd0);
    check("rst_res_data", {32'd0, res_data}, 64'd0);
    check("rst_res_row", {62'd0, res_row}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    read_check(zeros, -1, 0);

    for (int i = 0; i < 6; i++) begin
      send_cmd(vec[i].op, vec[i].a, vec[i].b);
      if (vec[i].op == OP_CLEAR) begin
        check("clear_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("clear_busy", {63'd0, busy}, 64'd0);
      end else begin
        check_compute();
      end
      read_check(vec[i].e, -1, 0);
    end

    // Back-pressure at row1 with an ignored CLEAR meanwhile
    send_cmd(OP_LOAD, 32'h04030201, 32'h01020304);
    check_compute();
    read_check(base, 1, 3);
    read_check(base, -1, 0);

    // Reset during the second COMPUTE cycle aborts and clears everything
    send_cmd(OP_LOAD, 32'h05060708, 32'h0A0B0C0D);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    rst_done = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (mac_done) rst_done++;
      @(negedge clk);
    end
    check("abort_mac_done", 64'(rst_done), 64'd0);
    read_check(zeros, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_mac_seq.md
Name: matrix_mac_seq

Overview:
- Parametrised, sequential outer-product multiply-accumulate engine for the core's matrix extension.
- Holds a LANES x LANES accumulator array internally and computes acc[r][c] (+)= A[c]*B[r], one row per cycle.
- Accumulator rows stream out through a valid/ready result port.
- Sits behind the EX stage as a multi-cycle functional unit; the pipeline stalls on cmd_ready.

Parameters:
- LANES, 4, elements per operand word and accumulator array dimension (>=2, power of 2).
- ELEM_W, 8, operand element width in bits (unsigned).
- ACC_W, 8, accumulator element width in bits (>= ELEM_W).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  unit idle and can accept a command.
- cmd_op  in  2  00 CLEAR, 01 MAC, 10 LOAD, 11 READ.
- op_A  in  LANES*ELEM_W  column operand; element c at [c*ELEM_W +: ELEM_W].
- op_B  in  LANES*ELEM_W  row operand; element r at [r*ELEM_W +: ELEM_W].
- res_valid  out  1  result row valid.
- res_ready  in  1  consumer accepts result row.
- res_data  out  LANES*ACC_W  accumulator row; lane c at [c*ACC_W +: ACC_W].
- res_row  out  clog2(LANES)  index of the row on res_data.
- mac_done  out  1  one-cycle pulse when a MAC/LOAD completes.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state IDLE; all accumulators 0; row counter 0.
  - res_valid 0, res_data 0, res_row 0, mac_done 0, busy 0.
  - cmd_ready = (state==IDLE), so it reads 1 during reset.
- Accept: a command is accepted on a rising edge with cmd_valid && cmd_ready. op_A/op_B are latched on accept; later changes on the inputs have no effect.
- States: IDLE, COMPUTE, READOUT.
- CLEAR:
  - Zeroes every accumulator on the accept edge.
  - The state stays IDLE; cmd_ready stays 1 (single-cycle command).
- MAC (accepted at edge T):
  - COMPUTE for LANES cycles.
  - At edge T+1+k, row k is written: acc[k][c] <= acc[k][c] + trunc(Alat[c]*Blat[k]), for all c.
  - mac_done is high for the single cycle after the last row write; the state returns to IDLE with it.
  - cmd_ready is low for exactly LANES cycles.
- LOAD: identical timing to MAC, but acc[k][c] <= trunc(Alat[c]*Blat[k]) (previous contents discarded).
- READ:
  - READOUT with the row counter at 0; res_valid is asserted the cycle after accept.
  - res_data shows acc[row]; res_row shows row.
  - On res_valid && res_ready the row increments. After row LANES-1 is accepted: res_valid drops and the state returns to IDLE.
  - While res_ready is low, res_data and res_row hold stable.
- Arithmetic:
  - Products are full 2*ELEM_W unsigned.
  - Sum formed at max(2*ELEM_W, ACC_W)+1 bits, then reduced to ACC_W.
  - Default reduction is modulo 2^ACC_W (wrap).
- Boundaries:
  - cmd_valid while busy: ignored and not queued.
  - cmd_op is a 2-bit decode and every encoding is defined (no illegal op).
  - rst asserted mid-COMPUTE or mid-READOUT aborts immediately. All accumulators clear, including partially updated rows.
  - mac_done and res_valid are never high in the same cycle.

Optional Feature:
- Macro: MATRIX_MAC_SAT_EN.
- Defined: the MAC/LOAD reduction to ACC_W is unsigned saturating. Any result >= 2^ACC_W stores 2^ACC_W-1.
- Undefined: the reduction wraps modulo 2^ACC_W. No saturation logic is generated.

Test Plan (LANES=4, ELEM_W=8, ACC_W=8):
- Reset, then READ with res_ready=1 -> four rows, res_row 0,1,2,3, res_data 0x00000000 each; cmd_ready returns to 1 the cycle after row 3.
- LOAD A=0x04030201, B=0x01020304 -> cmd_ready low 4 cycles, mac_done one pulse; READ gives row0 0x100C0804, row1 0x0C090603, row2 0x08060402, row3 0x04030201.
- MAC with the same operands after the previous step -> READ row0 0x20181008, row3 0x08060402.
- LOAD A=0x000000FF, B=0x000000FF -> row0 lane0 = 0x01 without the macro, 0xFF with MATRIX_MAC_SAT_EN; all other lanes 0.
- READ with res_ready held low 3 cycles at row1 -> res_data/res_row stable at row1; a cmd_valid=1, cmd_op=CLEAR issued meanwhile is ignored, and row1 data is still present when resumed.
- LOAD nonzero operands, then assert rst at the 2nd COMPUTE cycle -> busy=0 and mac_done never pulses; a subsequent READ returns all zeros.
